// File: rtl/nn_stream_loader.sv
// Stream front end for the 4-2 inference core: assembles 28 serial words into the
// core's x/w buses, strobes the core, and returns its two results as a 2-beat stream.
module nn_stream_loader #(
   parameter int unsigned DATA_W  = 5,
   parameter int unsigned RES_W   = 17,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic signed [DATA_W-1:0] s_data,
   output logic signed [DATA_W-1:0] x0,
   output logic signed [DATA_W-1:0] x1,
   output logic signed [DATA_W-1:0] x2,
   output logic signed [DATA_W-1:0] x3,
   output logic signed [DATA_W-1:0] w04,
   output logic signed [DATA_W-1:0] w05,
   output logic signed [DATA_W-1:0] w06,
   output logic signed [DATA_W-1:0] w07,
   output logic signed [DATA_W-1:0] w14,
   output logic signed [DATA_W-1:0] w15,
   output logic signed [DATA_W-1:0] w16,
   output logic signed [DATA_W-1:0] w17,
   output logic signed [DATA_W-1:0] w24,
   output logic signed [DATA_W-1:0] w25,
   output logic signed [DATA_W-1:0] w26,
   output logic signed [DATA_W-1:0] w27,
   output logic signed [DATA_W-1:0] w34,
   output logic signed [DATA_W-1:0] w35,
   output logic signed [DATA_W-1:0] w36,
   output logic signed [DATA_W-1:0] w37,
   output logic signed [DATA_W-1:0] w48,
   output logic signed [DATA_W-1:0] w58,
   output logic signed [DATA_W-1:0] w49,
   output logic signed [DATA_W-1:0] w59,
   output logic signed [DATA_W-1:0] w68,
   output logic signed [DATA_W-1:0] w69,
   output logic signed [DATA_W-1:0] w78,
   output logic signed [DATA_W-1:0] w79,
   output logic                     in_ready,
   input  logic [RES_W-1:0]         out0,
   input  logic [RES_W-1:0]         out1,
   input  logic                     out0_ready,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [RES_W-1:0]         m_data,
   output logic                     m_last,
   output logic                     busy,
   output logic                     timeout_err
);

   localparam int unsigned NUM_WORDS = 28;
   localparam int unsigned CNT_W     = $clog2(NUM_WORDS);
   localparam int unsigned WAIT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NUM_WORDS - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_FIRE,
      ST_WAIT,
      ST_SEND0,
      ST_SEND1
   } state_t;

   state_t                   state;
   logic [CNT_W-1:0]         word_cnt;
   logic [WAIT_W-1:0]        wait_cnt;
   logic [RES_W-1:0]         res1;
   logic signed [DATA_W-1:0] word_q [NUM_WORDS];

   // Sequencer: load, strobe, wait for the core, then hand back out0 and out1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_LOAD;
         word_cnt    <= '0;
         wait_cnt    <= '0;
         res1        <= '0;
         s_ready     <= 1'b1;
         in_ready    <= 1'b0;
         m_valid     <= 1'b0;
         m_data      <= '0;
         m_last      <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         for (int i = 0; i < NUM_WORDS; i++) begin
            word_q[i] <= '0;
         end
      end else begin
         in_ready <= 1'b0;
         case (state)
            ST_LOAD: begin
               if (s_valid && s_ready) begin
                  for (int i = 0; i < NUM_WORDS; i++) begin
                     if (word_cnt == CNT_W'(i)) begin
                        word_q[i] <= s_data;
                     end
                  end
                  if (word_cnt == LAST_IDX) begin
                     word_cnt <= '0;
                     state    <= ST_FIRE;
                     in_ready <= 1'b1;
                     s_ready  <= 1'b0;
                     busy     <= 1'b1;
                  end else begin
                     word_cnt <= word_cnt + CNT_W'(1);
                  end
               end
            end
            ST_FIRE: begin
               state    <= ST_WAIT;
               wait_cnt <= '0;
            end
            ST_WAIT: begin
               // x/w stay frozen here; the core samples output-layer weights late.
               if (out0_ready) begin
                  m_data  <= out0;
                  res1    <= out1;
                  m_valid <= 1'b1;
                  m_last  <= 1'b0;
                  state   <= ST_SEND0;
               end else if (wait_cnt == WAIT_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= ST_LOAD;
                  s_ready     <= 1'b1;
                  busy        <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ST_SEND0: begin
               if (m_ready) begin
                  m_data <= res1;
                  m_last <= 1'b1;
                  state  <= ST_SEND1;
               end
            end
            ST_SEND1: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  m_last  <= 1'b0;
                  state   <= ST_LOAD;
                  s_ready <= 1'b1;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state   <= ST_LOAD;
               s_ready <= 1'b1;
               busy    <= 1'b0;
               m_valid <= 1'b0;
            end
         endcase
      end
   end

   // Word index to core port mapping follows the stream order.
   assign x0  = word_q[0];
   assign x1  = word_q[1];
   assign x2  = word_q[2];
   assign x3  = word_q[3];
   assign w04 = word_q[4];
   assign w05 = word_q[5];
   assign w06 = word_q[6];
   assign w07 = word_q[7];
   assign w14 = word_q[8];
   assign w15 = word_q[9];
   assign w16 = word_q[10];
   assign w17 = word_q[11];
   assign w24 = word_q[12];
   assign w25 = word_q[13];
   assign w26 = word_q[14];
   assign w27 = word_q[15];
   assign w34 = word_q[16];
   assign w35 = word_q[17];
   assign w36 = word_q[18];
   assign w37 = word_q[19];
   assign w48 = word_q[20];
   assign w58 = word_q[21];
   assign w49 = word_q[22];
   assign w59 = word_q[23];
   assign w68 = word_q[24];
   assign w69 = word_q[25];
   assign w78 = word_q[26];
   assign w79 = word_q[27];

endmodule

// File: tb/tb_nn_stream_loader.sv
// Directed bench for nn_stream_loader with a behavioural 4-2 core attached.
module tb_nn_stream_loader;

   logic clk = 1'b0;
   logic rst, s_valid, m_ready;
   logic signed [4:0] s_data;
   logic s_ready, in_ready, m_valid, m_last, busy, timeout_err;
   logic [16:0] m_data, out0, out1;
   logic out0_ready;
   logic signed [4:0] x0, x1, x2, x3;
   logic signed [4:0] w04, w05, w06, w07, w14, w15, w16, w17;
   logic signed [4:0] w24, w25, w26, w27, w34, w35, w36, w37;
   logic signed [4:0] w48, w58, w49, w59, w68, w69, w78, w79;

   always #5 clk = ~clk;

   nn_stream_loader dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .x0(x0), .x1(x1), .x2(x2), .x3(x3),
      .w04(w04), .w05(w05), .w06(w06), .w07(w07), .w14(w14), .w15(w15), .w16(w16), .w17(w17),
      .w24(w24), .w25(w25), .w26(w26), .w27(w27), .w34(w34), .w35(w35), .w36(w36), .w37(w37),
      .w48(w48), .w58(w58), .w49(w49), .w59(w59), .w68(w68), .w69(w69), .w78(w78), .w79(w79),
      .in_ready(in_ready), .out0(out0), .out1(out1), .out0_ready(out0_ready),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .timeout_err(timeout_err)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0, acc_cnt = 0, fire_cnt = 0, mv_cnt = 0;
   logic [2:0] pipe = 3'b000;
   logic core_en = 1'b1;
   logic signed [4:0] vec [28];
   logic [4:0] pv [28];

   assign pv[0]  = x0;  assign pv[1]  = x1;  assign pv[2]  = x2;  assign pv[3]  = x3;
   assign pv[4]  = w04; assign pv[5]  = w05; assign pv[6]  = w06; assign pv[7]  = w07;
   assign pv[8]  = w14; assign pv[9]  = w15; assign pv[10] = w16; assign pv[11] = w17;
   assign pv[12] = w24; assign pv[13] = w25; assign pv[14] = w26; assign pv[15] = w27;
   assign pv[16] = w34; assign pv[17] = w35; assign pv[18] = w36; assign pv[19] = w37;
   assign pv[20] = w48; assign pv[21] = w58; assign pv[22] = w49; assign pv[23] = w59;
   assign pv[24] = w68; assign pv[25] = w69; assign pv[26] = w78; assign pv[27] = w79;

   // Event monitors and the core's 3-cycle result latency.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (s_valid && s_ready) acc_cnt <= acc_cnt + 1;
      if (in_ready) fire_cnt <= fire_cnt + 1;
      if (m_valid) mv_cnt <= mv_cnt + 1;
      pipe <= {pipe[1:0], in_ready};
   end

   function automatic int relu(input int v);
      return (v > 0) ? v : 0;
   endfunction

   int h4, h5, h6, h7;
   always_comb begin
      h4 = relu(int'(x0)*int'(w04) + int'(x1)*int'(w14) + int'(x2)*int'(w24) + int'(x3)*int'(w34));
      h5 = relu(int'(x0)*int'(w05) + int'(x1)*int'(w15) + int'(x2)*int'(w25) + int'(x3)*int'(w35));
      h6 = relu(int'(x0)*int'(w06) + int'(x1)*int'(w16) + int'(x2)*int'(w26) + int'(x3)*int'(w36));
      h7 = relu(int'(x0)*int'(w07) + int'(x1)*int'(w17) + int'(x2)*int'(w27) + int'(x3)*int'(w37));
      out0 = 17'(h4*int'(w48) + h5*int'(w58) + h6*int'(w68) + h7*int'(w78));
      out1 = 17'(h4*int'(w49) + h5*int'(w59) + h6*int'(w69) + h7*int'(w79));
   end
   assign out0_ready = pipe[2] & core_en;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_vec(input bit toggle);
      int i = 0;
      int g = 0;
      while (i < 28 && g < 400) begin
         s_valid = toggle ? ((g % 2) == 0) : 1'b1;
         s_data  = vec[i];
         if (s_valid && s_ready) i++;
         tick();
         g++;
      end
      s_valid = 1'b0;
   endtask

   task automatic get_beats(output int n, output logic [16:0] d0, output logic l0,
                            output logic [16:0] d1, output logic l1);
      n = 0;
      m_ready = 1'b1;
      while (!m_valid && n < 20) begin
         tick();
         n++;
      end
      d0 = m_data; l0 = m_last;
      tick();
      d1 = m_data; l1 = m_last;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if (s_ready !== 1'b1 || in_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== 17'd0 ||
          m_last !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got s_ready=%b in_ready=%b m_valid=%b m_data=%h m_last=%b busy=%b terr=%b want 1 0 0 0 0 0 0",
                  s_ready, in_ready, m_valid, m_data, m_last, busy, timeout_err);
      end
      checks++;
      if (x0 !== 5'sd0 || w37 !== 5'sd0 || w79 !== 5'sd0) begin
         errors++;
         $display("FAIL reset_regs got x0=%0d w37=%0d w79=%0d want 0", x0, w37, w79);
      end
      tick();
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_s_ready got %b want 1", s_ready);
      end
   endtask

   task automatic test_all_ones();
      int n, c0, f0;
      logic [16:0] d0, d1;
      logic l0, l1;
      for (int i = 0; i < 28; i++) vec[i] = 5'sd1;
      m_ready = 1'b1;
      f0 = fire_cnt;
      c0 = cyc;
      load_vec(1'b0);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL ones_fire got in_ready=%b busy=%b s_ready=%b want 1 1 0", in_ready, busy, s_ready);
      end
      get_beats(n, d0, l0, d1, l1);
      checks++;
      if (n !== 4) begin
         errors++;
         $display("FAIL ones_latency got %0d want 4 cycles from strobe to first beat", n);
      end
      checks++;
      if (d0 !== 17'd16 || l0 !== 1'b0) begin
         errors++;
         $display("FAIL ones_beat0 got %0d last=%b want 16 last=0", d0, l0);
      end
      checks++;
      if (d1 !== 17'd16 || l1 !== 1'b1) begin
         errors++;
         $display("FAIL ones_beat1 got %0d last=%b want 16 last=1", d1, l1);
      end
      checks++;
      if (fire_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL ones_strobes got %0d want 1", fire_cnt - f0);
      end
      checks++;
      if (cyc - c0 !== 34) begin
         errors++;
         $display("FAIL ones_turnaround got %0d want 34", cyc - c0);
      end
      checks++;
      if (s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL ones_idle got s_ready=%b busy=%b m_valid=%b want 1 0 0", s_ready, busy, m_valid);
      end
   endtask

   task automatic test_relu();
      int n;
      logic [16:0] d0, d1;
      logic l0, l1;
      for (int i = 0; i < 28; i++) vec[i] = 5'sd0;
      vec[0] = -5'sd1; vec[4] = 5'sd1; vec[20] = 5'sd3; vec[22] = -5'sd2;
      load_vec(1'b0);
      get_beats(n, d0, l0, d1, l1);
      checks++;
      if (d0 !== 17'd0 || d1 !== 17'd0) begin
         errors++;
         $display("FAIL relu_clamp got %h %h want 00000 00000", d0, d1);
      end
      vec[0] = 5'sd2;
      load_vec(1'b0);
      get_beats(n, d0, l0, d1, l1);
      checks++;
      if (d0 !== 17'd6 || l0 !== 1'b0) begin
         errors++;
         $display("FAIL relu_pos_beat0 got %h last=%b want 00006 last=0", d0, l0);
      end
      checks++;
      if (d1 !== 17'h1FFFC || l1 !== 1'b1) begin
         errors++;
         $display("FAIL relu_neg_beat1 got %h last=%b want 1fffc last=1", d1, l1);
      end
   endtask

   task automatic test_toggle_valid();
      int n, a0, f0;
      logic [16:0] d0, d1;
      logic l0, l1;
      for (int i = 0; i < 28; i++) vec[i] = 5'(i + 1);
      a0 = acc_cnt;
      f0 = fire_cnt;
      load_vec(1'b1);
      checks++;
      if (acc_cnt - a0 !== 28) begin
         errors++;
         $display("FAIL toggle_accepts got %0d want 28", acc_cnt - a0);
      end
      checks++;
      if (in_ready !== 1'b1 || fire_cnt !== f0) begin
         errors++;
         $display("FAIL toggle_strobe got in_ready=%b earlier=%0d want 1 0", in_ready, fire_cnt - f0);
      end
      tick();
      for (int i = 0; i < 28; i++) begin
         checks++;
         if (pv[i] !== 5'(i + 1)) begin
            errors++;
            $display("FAIL toggle_map idx %0d got %0d want %0d", i, pv[i], i + 1);
         end
      end
      get_beats(n, d0, l0, d1, l1);
      checks++;
      if (n >= 20 || l1 !== 1'b1) begin
         errors++;
         $display("FAIL toggle_drain got wait=%0d last=%b want <20 1", n, l1);
      end
   endtask

   task automatic test_backpressure();
      int n, a0, f0;
      logic [16:0] d0, d1;
      logic l0, l1;
      for (int i = 0; i < 28; i++) vec[i] = 5'sd1;
      m_ready = 1'b0;
      load_vec(1'b0);
      f0 = fire_cnt;
      n = 0;
      while (!m_valid && n < 20) begin
         tick();
         n++;
      end
      a0 = acc_cnt;
      s_valid = 1'b1;
      s_data  = 5'sd7;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== 17'd16 || m_last !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_cycle %0d got m_valid=%b m_data=%0d m_last=%b s_ready=%b want 1 16 0 0",
                     k, m_valid, m_data, m_last, s_ready);
         end
         tick();
      end
      s_valid = 1'b0;
      checks++;
      if (acc_cnt !== a0 || fire_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL stall_side got accepts=%0d strobes=%0d want 0 1", acc_cnt - a0, fire_cnt - f0);
      end
      get_beats(n, d0, l0, d1, l1);
      checks++;
      if (d0 !== 17'd16 || l0 !== 1'b0 || d1 !== 17'd16 || l1 !== 1'b1) begin
         errors++;
         $display("FAIL stall_beats got %0d/%b %0d/%b want 16/0 16/1", d0, l0, d1, l1);
      end
   endtask

   task automatic test_timeout();
      int n, m0;
      logic [16:0] d0, d1;
      logic l0, l1;
      core_en = 1'b0;
      for (int i = 0; i < 28; i++) vec[i] = 5'sd1;
      m0 = mv_cnt;
      load_vec(1'b0);
      for (int k = 0; k < 15; k++) tick();
      checks++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early got terr=%b busy=%b want 0 1", timeout_err, busy);
      end
      tick();
      checks++;
      if (timeout_err !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL timeout_abort got terr=%b s_ready=%b busy=%b m_valid=%b want 1 1 0 0",
                  timeout_err, s_ready, busy, m_valid);
      end
      checks++;
      if (mv_cnt !== m0) begin
         errors++;
         $display("FAIL timeout_no_beats got %0d want 0", mv_cnt - m0);
      end
      core_en = 1'b1;
      load_vec(1'b0);
      get_beats(n, d0, l0, d1, l1);
      checks++;
      if (d0 !== 17'd16 || d1 !== 17'd16 || timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky got %0d %0d terr=%b want 16 16 1", d0, d1, timeout_err);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      logic [16:0] d0, d1;
      logic l0, l1;
      for (int i = 0; i < 28; i++) vec[i] = 5'sd1;
      m_ready = 1'b1;
      load_vec(1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (s_ready !== 1'b1 || in_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== 17'd0 ||
          busy !== 1'b0 || timeout_err !== 1'b0 || x0 !== 5'sd0 || w79 !== 5'sd0) begin
         errors++;
         $display("FAIL rst_wait got s_ready=%b in_ready=%b m_valid=%b m_data=%0d busy=%b terr=%b x0=%0d w79=%0d want 1 0 0 0 0 0 0 0",
                  s_ready, in_ready, m_valid, m_data, busy, timeout_err, x0, w79);
      end
      for (int i = 0; i < 10; i++) begin
         s_valid = 1'b1;
         s_data  = 5'sd3;
         tick();
      end
      s_valid = 1'b0;
      checks++;
      if (w14 !== 5'sd3 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_partial got w14=%0d m_valid=%b want 3 0", w14, m_valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (x0 !== 5'sd0 || w14 !== 5'sd0 || s_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_load got x0=%0d w14=%0d s_ready=%b busy=%b want 0 0 1 0", x0, w14, s_ready, busy);
      end
      for (int i = 0; i < 28; i++) vec[i] = 5'(i + 3);
      load_vec(1'b0);
      tick();
      checks++;
      if (pv[0] !== 5'd3 || pv[27] !== 5'd30) begin
         errors++;
         $display("FAIL rst_reload got x0=%0d w79=%0d want 3 30", pv[0], pv[27]);
      end
      get_beats(n, d0, l0, d1, l1);
      checks++;
      if (n >= 20 || l1 !== 1'b1) begin
         errors++;
         $display("FAIL rst_drain got wait=%0d last=%b want <20 1", n, l1);
      end
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      test_reset();
      test_all_ones();
      test_relu();
      test_toggle_valid();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no completion want finish before 200000ns");
      $fatal(1, "watchdog expired");
   end

endmodule
